mux_4to1: RTL and testbench
===========================

MUX_4TO1 -- requirements
Module: mux_4to1

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter WIDTH, default 1: bit width of each data input and of y.
REQ-003 clk  input  1  rising-edge clock; used only when MUX_4TO1_OUT_REG_EN is defined.
REQ-004 rst  input  1  synchronous active-high reset; used only when MUX_4TO1_OUT_REG_EN is defined.
REQ-005 i0  input  WIDTH  data input, selected when {s1,s0}=00.
REQ-006 i1  input  WIDTH  data input, selected when {s1,s0}=01.
REQ-007 i2  input  WIDTH  data input, selected when {s1,s0}=10.
REQ-008 i3  input  WIDTH  data input, selected when {s1,s0}=11.
REQ-009 s0  input  1  select LSB.
REQ-010 s1  input  1  select MSB.
REQ-011 y  output  WIDTH  selected data.
REQ-012 s0_bar  output  1  inverted s0.
REQ-013 s1_bar  output  1  inverted s1.

Function
REQ-014 Select encoding SHALL be {s1,s0}: 00->i0, 01->i1, 10->i2, 11->i3.
REQ-015 Without MUX_4TO1_OUT_REG_EN, y SHALL be purely combinational with zero-cycle latency; no latches.
REQ-016 s0_bar = ~s0 and s1_bar = ~s1 SHALL always be combinational, in both configurations.
REQ-017 Non-selected inputs SHALL have no effect on y.
REQ-018 X/Z on s0 or s1 SHALL not be masked; an unknown select in simulation is permitted to yield X on y.
REQ-019 All WIDTH bits SHALL be selected by the same {s1,s0}; there is no per-bit selection.
REQ-020 When {s1,s0} and the selected input change in the same time step, y SHALL reflect the new select with the new input value.

Reset
REQ-021 Without MUX_4TO1_OUT_REG_EN, rst and clk SHALL have no effect; the block SHALL operate correctly with both ports left unconnected.
REQ-022 With MUX_4TO1_OUT_REG_EN, rst=1 sampled at a rising clk edge SHALL set y to all zeros; rst SHALL take priority over the data update.
REQ-023 s0_bar and s1_bar SHALL never be affected by rst.
REQ-024 Deasserting rst SHALL resume normal registered operation at the next rising edge.

Configuration
REQ-025 The macro MUX_4TO1_OUT_REG_EN SHALL control the output register.
REQ-026 When MUX_4TO1_OUT_REG_EN is undefined (default), y SHALL be combinational per REQ-015.
REQ-027 When MUX_4TO1_OUT_REG_EN is defined, y SHALL be a register loaded at each rising clk edge with the value selected by the select and data inputs sampled at that edge (latency one cycle).
REQ-028 In the registered configuration, y SHALL hold its value between edges regardless of input activity.

Verification
REQ-029 Comb: {s1,s0}=00, {i0,i1,i2,i3}=1000, wait 10 ns -> y=1, s0_bar=1, s1_bar=1.
REQ-030 Comb: {s1,s0}=01, inputs=0100 -> y=1, s0_bar=0, s1_bar=1; then {s1,s0}=10, inputs=0010 -> y=1, s0_bar=1, s1_bar=0.
REQ-031 Comb: {s1,s0}=11, inputs=0001 -> y=1, s0_bar=0, s1_bar=0; then inputs=1110 with the same select -> y=0.
REQ-032 Comb, exhaustive: all 64 combinations of select and inputs -> y equals the selected input in every case.
REQ-033 Registered (WIDTH=8): rst=1 for 2 cycles -> y=0x00; release, sel=10, i2=0xA5 -> y=0xA5 one edge later, unchanged before that edge.
REQ-034 Registered: assert rst mid-stream while sel=11, i3=0xFF -> y=0x00 at that edge; s1_bar=0 and s0_bar=0 are unchanged throughout.

Source files
------------

// File: rtl/mux_4to1.sv
// -----------------------------------------------------------------------------
// mux_4to1 -- WIDTH-bit 4:1 multiplexer with inverted select outputs.
//
// Select encoding {s1,s0}: 00 -> i0, 01 -> i1, 10 -> i2, 11 -> i3.
// s0_bar / s1_bar are always combinational inversions of the selects.
//
// Optional feature macro: MUX_4TO1_OUT_REG_EN
//   undefined (default): y is purely combinational; clk and rst are ignored
//                        and may be left unconnected.
//   defined            : y is registered on the rising edge of clk (one cycle
//                        latency), with synchronous active-high rst clearing
//                        it to zero and taking priority over the load.
// -----------------------------------------------------------------------------
module mux_4to1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic             s0,
  input  logic             s1,
  output logic [WIDTH-1:0] y,
  output logic             s0_bar,
  output logic             s1_bar
);

  // One shared select word drives every bit lane, so there is no per-bit
  // selection anywhere in the datapath.
  logic [1:0]       sel;
  logic [WIDTH-1:0] y_sel;

  assign sel = {s1, s0};

  // Steer the addressed input onto y_sel; an unknown select yields X in
  // simulation rather than being silently masked to a legal input.
  always_comb begin
    // NOTE: y_sel gets a value before the case so every path through the
    // block assigns it; a missing branch would otherwise infer a latch.
    y_sel = {WIDTH{1'bx}};
    case (sel)
      2'b00:   y_sel = i0;
      2'b01:   y_sel = i1;
      2'b10:   y_sel = i2;
      2'b11:   y_sel = i3;
      default: y_sel = {WIDTH{1'bx}};
    endcase
  end

  // Select inversions are independent of the output configuration and of rst.
  assign s0_bar = ~s0;
  assign s1_bar = ~s1;

`ifdef MUX_4TO1_OUT_REG_EN

  // Output register: clear on rst, otherwise capture the selected input.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignment so every flop
    // samples pre-edge values, independent of process evaluation order.
    // Only y is cleared here; the select inversions stay combinational and
    // are deliberately outside the reset domain.
    if (rst) begin
      y <= '0;
    end else begin
      y <= y_sel;
    end
  end

`else

  // Combinational output: zero-cycle latency from select and data to y.
  assign y = y_sel;

  // clk and rst exist only for port compatibility with the registered build.
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst};

`endif

endmodule

// File: tb/tb_mux_4to1.sv
// -----------------------------------------------------------------------------
// tb_mux_4to1 -- self-checking bench for mux_4to1.
//
// Two instances share the select, clock and reset: u_dut1 (WIDTH=1) and
// u_dut8 (WIDTH=8). Expected results are pushed to a scoreboard queue when
// stimulus is driven and popped when the output is sampled. The bench follows
// MUX_4TO1_OUT_REG_EN so it exercises whichever configuration is built.
// -----------------------------------------------------------------------------
module tb_mux_4to1;

  typedef struct {
    logic [7:0] y;
    logic       s0b;
    logic       s1b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       s0, s1;
  logic       a0, a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;
  logic       ya;
  logic [7:0] yb;
  logic       a_s0_bar, a_s1_bar;
  logic       b_s0_bar, b_s1_bar;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mux_4to1 #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .i0(a0), .i1(a1), .i2(a2), .i3(a3),
    .s0(s0), .s1(s1),
    .y(ya), .s0_bar(a_s0_bar), .s1_bar(a_s1_bar)
  );

  mux_4to1 #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .i0(b0), .i1(b1), .i2(b2), .i3(b3),
    .s0(s0), .s1(s1),
    .y(yb), .s0_bar(b_s0_bar), .s1_bar(b_s1_bar)
  );

  // Reference selection: {s1,s0} indexes the four inputs.
  function automatic logic [7:0] ref_mux(input logic [1:0] sel,
                                         input logic [7:0] d0, input logic [7:0] d1,
                                         input logic [7:0] d2, input logic [7:0] d3);
    logic [7:0] r;
    if      (sel == 2'd0) r = d0;
    else if (sel == 2'd1) r = d1;
    else if (sel == 2'd2) r = d2;
    else                  r = d3;
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] y, input logic s0b, input logic s1b);
    exp_t e;
    e.y = y; e.s0b = s0b; e.s1b = s1b;
    sb.push_back(e);
  endtask

  // Pop one expectation and compare it against one instance's outputs.
  task automatic pop_check(input string tag, input logic [7:0] obs_y,
                           input logic obs_s0b, input logic obs_s1b);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".y"},      obs_y,          e.y);
      check({tag, ".s0_bar"}, {7'd0, obs_s0b}, {7'd0, e.s0b});
      check({tag, ".s1_bar"}, {7'd0, obs_s1b}, {7'd0, e.s1b});
    end
  endtask

  // Drive the 1-bit instance; d is {i0,i1,i2,i3} as written in the vectors.
  task automatic drive_a(input logic [1:0] sel, input logic [3:0] d);
    {s1, s0} = sel;
    a0 = d[3]; a1 = d[2]; a2 = d[1]; a3 = d[0];
    push_exp(ref_mux(sel, {7'd0, d[3]}, {7'd0, d[2]}, {7'd0, d[1]}, {7'd0, d[0]}),
             ~sel[0], ~sel[1]);
  endtask

  // Drive the 8-bit instance.
  task automatic drive_b(input logic [1:0] sel, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3);
    {s1, s0} = sel;
    b0 = d0; b1 = d1; b2 = d2; b3 = d3;
    push_exp(ref_mux(sel, d0, d1, d2, d3), ~sel[0], ~sel[1]);
  endtask

  initial begin
    rst = 1'b0;
    s0 = 1'b0; s1 = 1'b0;
    a0 = 1'b0; a1 = 1'b0; a2 = 1'b0; a3 = 1'b0;
    b0 = 8'h00; b1 = 8'h00; b2 = 8'h00; b3 = 8'h00;

`ifdef MUX_4TO1_OUT_REG_EN
    // Reset held for two edges with live, nonzero inputs.
    rst = 1'b1;
    drive_b(2'b10, 8'h12, 8'h34, 8'h33, 8'h56);
    sb.pop_front();
    repeat (2) @(posedge clk);
    #1;
    push_exp(8'h00, 1'b1, 1'b0);
    pop_check("reset", yb, b_s0_bar, b_s1_bar);
    check("reset_w1", {7'd0, ya}, 8'h00);

    // Release and load A5; y must not move before the edge.
    @(negedge clk);
    rst = 1'b0;
    drive_b(2'b10, 8'h12, 8'h34, 8'hA5, 8'h56);
    #1 check("pre_edge_hold", yb, 8'h00);
    @(posedge clk);
    #1 pop_check("load_a5", yb, b_s0_bar, b_s1_bar);

    // Mid-cycle input activity must not disturb the registered y.
    @(negedge clk);
    drive_b(2'b01, 8'h77, 8'h11, 8'h5A, 8'h99);
    #1 check("between_edges", yb, 8'hA5);
    @(posedge clk);
    #1 pop_check("load_11", yb, b_s0_bar, b_s1_bar);

    // Random registered traffic, one transaction per cycle.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      drive_b(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
              8'($urandom), 8'($urandom));
      @(posedge clk);
      #1 pop_check("reg_rand", yb, b_s0_bar, b_s1_bar);
    end

    // Mid-stream reset with sel=11, i3=FF, then resume.
    @(negedge clk);
    drive_b(2'b11, 8'h01, 8'h02, 8'h03, 8'hFF);
    @(posedge clk);
    #1 pop_check("sel11_ff", yb, b_s0_bar, b_s1_bar);
    @(negedge clk);
    rst = 1'b1;
    push_exp(8'h00, 1'b0, 1'b0);
    #1 check("rst_bars", {6'd0, b_s1_bar, b_s0_bar}, 8'h00);
    @(posedge clk);
    #1 pop_check("mid_rst", yb, b_s0_bar, b_s1_bar);
    @(negedge clk);
    rst = 1'b0;
    push_exp(8'hFF, 1'b0, 1'b0);
    #1 check("rst_release_hold", yb, 8'h00);
    @(posedge clk);
    #1 pop_check("resume", yb, b_s0_bar, b_s1_bar);
`else
    // Directed vectors on the 1-bit instance.
    drive_a(2'b00, 4'b1000);
    #10 pop_check("sel00", {7'd0, ya}, a_s0_bar, a_s1_bar);
    drive_a(2'b01, 4'b0100);
    #10 pop_check("sel01", {7'd0, ya}, a_s0_bar, a_s1_bar);
    drive_a(2'b10, 4'b0010);
    #10 pop_check("sel10", {7'd0, ya}, a_s0_bar, a_s1_bar);
    drive_a(2'b11, 4'b0001);
    #10 pop_check("sel11", {7'd0, ya}, a_s0_bar, a_s1_bar);
    drive_a(2'b11, 4'b1110);
    #10 pop_check("sel11_zero", {7'd0, ya}, a_s0_bar, a_s1_bar);

    // Exhaustive: 4 selects x 16 input patterns.
    for (int s = 0; s < 4; s++) begin
      for (int d = 0; d < 16; d++) begin
        drive_a(2'(s), 4'(d));
        #1 pop_check("exh", {7'd0, ya}, a_s0_bar, a_s1_bar);
      end
    end

    // Select and newly selected input change in the same time step.
    drive_a(2'b00, 4'b0000);
    #1 pop_check("same_step_pre", {7'd0, ya}, a_s0_bar, a_s1_bar);
    drive_a(2'b01, 4'b0100);
    #1 pop_check("same_step", {7'd0, ya}, a_s0_bar, a_s1_bar);

    // 8-bit lanes: random patterns catch any per-bit select fault.
    for (int k = 0; k < 16; k++) begin
      drive_b(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
              8'($urandom), 8'($urandom));
      #1 pop_check("w8_rand", yb, b_s0_bar, b_s1_bar);
    end

    // Non-selected inputs toggle while i2 is held under sel=10.
    drive_b(2'b10, 8'h00, 8'h00, 8'hC3, 8'h00);
    #1 pop_check("nonsel_base", yb, b_s0_bar, b_s1_bar);
    for (int k = 0; k < 4; k++) begin
      b0 = 8'($urandom); b1 = 8'($urandom); b3 = 8'($urandom);
      #1 check("nonsel_hold", yb, 8'hC3);
    end

    // rst and clk have no effect on the combinational output.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("rst_ignored", yb, 8'hC3);
    rst = 1'b0;
    drive_b(2'b01, 8'h00, 8'h6E, 8'hC3, 8'h00);
    #1 pop_check("no_clk_needed", yb, b_s0_bar, b_s1_bar);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
